// File: rtl/ysyx_22040127_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op field positions, controller states, constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ysyx_22040127_mdu_pkg;

   localparam int XLEN = 64;

   // in_op field positions
   localparam int OP_UNS = 0;   // 1 = unsigned
   localparam int OP_REM = 1;   // 1 = remainder, 0 = quotient
   localparam int OP_W   = 2;   // 1 = 32-bit word op

   // Cycles from the accept edge to out_valid for an op that goes through the divider
   localparam int DIV_LAT = 68;

   localparam logic [XLEN-1:0] INT64_MIN      = 64'h8000_0000_0000_0000;
   localparam logic [XLEN-1:0] INT32_MIN_SEXT = 64'hFFFF_FFFF_8000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } div_state_e;

   // Word ops return the low 32 bits sign-extended to XLEN
   function automatic logic [XLEN-1:0] fix_w(input logic w, input logic [XLEN-1:0] v);
      return w ? {{32{v[31]}}, v[31:0]} : v;
   endfunction

endpackage

// File: rtl/ysyx_22040127_div_ctrl.sv
// Sequencer between the EXU and the iterative divider: decodes RV64M divide ops, prepares operands, resolves div-by-zero/overflow locally.
// Latency: 68 cycles accept-to-out_valid through the divider; special cases are in DONE directly after the accept edge.
// Backpressure: in_ready only in IDLE (one op in flight); result held in DONE until out_ready; flushes drain an in-flight divide.
module ysyx_22040127_div_ctrl
   import ysyx_22040127_mdu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            in_flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_res,
   output logic [XLEN-1:0] div_x,
   output logic [XLEN-1:0] div_y,
   output logic            div_s,
   output logic            div_start,
   input  logic            div_ready,
   input  logic [XLEN-1:0] div_quo,
   input  logic [XLEN-1:0] div_rem
);

   div_state_e      state_q, state_d;

   logic [XLEN-1:0] prep_a, prep_b;
   logic            is_div0, is_ovf, is_special;
   logic [XLEN-1:0] spec_res;
   logic            accept;

   logic            op_w_q, op_rem_q;
   logic [XLEN-1:0] res_q;
   logic [XLEN-1:0] div_x_q, div_y_q;
   logic            div_s_q, div_start_q;

   // Operand preparation: word ops extend the low 32 bits according to signedness
   always_comb begin
      prep_a = in_a;
      prep_b = in_b;
      if (in_op[OP_W]) begin
         if (in_op[OP_UNS]) begin
            prep_a = {32'b0, in_a[31:0]};
            prep_b = {32'b0, in_b[31:0]};
         end else begin
            prep_a = {{32{in_a[31]}}, in_a[31:0]};
            prep_b = {{32{in_b[31]}}, in_b[31:0]};
         end
      end
   end

   // Special cases resolved without the divider: divide-by-zero and signed MIN / -1
   always_comb begin
      is_div0    = (prep_b == '0);
      is_ovf     = !in_op[OP_UNS] && (&prep_b) &&
                   (prep_a == (in_op[OP_W] ? INT32_MIN_SEXT : INT64_MIN));
      is_special = is_div0 || is_ovf;
      if (is_div0) begin
         spec_res = in_op[OP_REM] ? prep_a : '1;
      end else begin
         spec_res = in_op[OP_REM] ? '0 : prep_a;
      end
      spec_res = fix_w(in_op[OP_W], spec_res);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; in_ready/out_valid decode the state register only
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid && !in_flush;
            if (accept) begin
               state_d = is_special ? DONE : BUSY;
            end
         end
         BUSY: begin
            // flush wins over a simultaneous div_ready: the result is dropped
            if (in_flush && div_ready) begin
               state_d = IDLE;
            end else if (in_flush) begin
               state_d = DRAIN;
            end else if (div_ready) begin
               state_d = DONE;
            end
         end
         DRAIN: begin
            // the divider cannot be aborted; wait for it to finish, discard its result
            if (div_ready) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (in_flush || out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers: divider operands are only written on accept, so they hold until div_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_w_q      <= 1'b0;
         op_rem_q    <= 1'b0;
         res_q       <= '0;
         div_x_q     <= '0;
         div_y_q     <= '0;
         div_s_q     <= 1'b0;
         div_start_q <= 1'b0;
      end else begin
         div_start_q <= accept && !is_special;
         if (accept) begin
            op_w_q   <= in_op[OP_W];
            op_rem_q <= in_op[OP_REM];
            if (is_special) begin
               res_q <= spec_res;
            end else begin
               div_x_q <= prep_a;
               div_y_q <= prep_b;
               div_s_q <= !in_op[OP_UNS];
            end
         end
         if (state_q == BUSY && div_ready && !in_flush) begin
            res_q <= fix_w(op_w_q, op_rem_q ? div_rem : div_quo);
         end
      end
   end

   assign out_res   = res_q;
   assign div_x     = div_x_q;
   assign div_y     = div_y_q;
   assign div_s     = div_s_q;
   assign div_start = div_start_q;

endmodule

// File: tb/tb_ysyx_22040127_div_ctrl.sv
// Bench for the divide controller: behavioural divider, scoreboard of expected results, directed and random ops.
// Latency: checks 68 cycles through the divider and same-cycle-as-accept DONE for special cases.
// Backpressure: exercises out_ready stalls, flushes in IDLE/BUSY/DONE and reset mid-operation.
module tb_ysyx_22040127_div_ctrl;
   import ysyx_22040127_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_flush;
   logic [2:0]  in_op;
   logic [63:0] in_a, in_b;
   logic        out_valid, out_ready;
   logic [63:0] out_res;
   logic [63:0] div_x, div_y;
   logic        div_s, div_start;
   logic        div_ready;
   logic [63:0] div_quo, div_rem;

   ysyx_22040127_div_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_flush  (in_flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .div_x     (div_x),
      .div_y     (div_y),
      .div_s     (div_s),
      .div_start (div_start),
      .div_ready (div_ready),
      .div_quo   (div_quo),
      .div_rem   (div_rem)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int n_start = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural divider: samples is_div on an edge, pulses ready 66 edges later; synchronous reset
   logic        m_busy;
   logic [6:0]  m_cnt;
   logic [63:0] m_x, m_y;
   logic        m_s;
   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy    <= 1'b0;
         m_cnt     <= '0;
         div_ready <= 1'b0;
         div_quo   <= '0;
         div_rem   <= '0;
      end else begin
         div_ready <= 1'b0;
         if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 7'd66;
            m_x    <= div_x;
            m_y    <= div_y;
            m_s    <= div_s;
            if (div_y == 64'd0) begin
               div_quo <= '1;
               div_rem <= div_x;
            end else if (div_s) begin
               div_quo <= 64'($signed(div_x) / $signed(div_y));
               div_rem <= 64'($signed(div_x) % $signed(div_y));
            end else begin
               div_quo <= div_x / div_y;
               div_rem <= div_x % div_y;
            end
         end else if (m_busy) begin
            m_cnt <= m_cnt - 7'd1;
            if (m_cnt == 7'd1) begin
               div_ready <= 1'b1;
               m_busy    <= 1'b0;
            end
         end
      end
   end

   typedef struct {
      logic [63:0] res;
      int          due;
   } exp_t;
   exp_t sb[$];

   // Output monitor: latency on rising out_valid, stability while stalled, result on handshake,
   // divider operand hold while busy, div_start pulse width
   logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_start = 1'b0;
   logic [63:0] prev_res = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_vld   <= 1'b0;
         prev_start <= 1'b0;
      end else begin
         if (out_valid && !prev_vld && sb.size() > 0)
            check("latency", 64'(cyc), 64'(sb[0].due));
         if (out_valid && prev_vld && !prev_rdy)
            check("res_stable", out_res, prev_res);
         if (out_valid && out_ready) begin
            check("result_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("out_res", out_res, e.res);
            end
         end
         if (m_busy) begin
            check("div_x_hold", div_x, m_x);
            check("div_y_hold", div_y, m_y);
            check("div_s_hold", 64'(div_s), 64'(m_s));
         end
         if (div_start) begin
            n_start++;
            check("start_pulse", 64'(prev_start), 64'd0);
         end
         prev_vld   <= out_valid;
         prev_rdy   <= out_ready;
         prev_res   <= out_res;
         prev_start <= div_start;
      end
   end

   // Reference RV64M divide: returns {special, result}
   function automatic logic [64:0] ref_div(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, r32;
      logic [63:0] r;
      logic        sp;
      sp = 1'b1;
      if (op[2]) begin
         a32 = a[31:0];
         b32 = b[31:0];
         if (b32 == 32'd0) begin
            r32 = op[1] ? a32 : 32'hFFFF_FFFF;
         end else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            r32 = op[1] ? 32'd0 : a32;
         end else begin
            sp = 1'b0;
            if (op[0] && op[1])      r32 = a32 % b32;
            else if (op[0])          r32 = a32 / b32;
            else if (op[1])          r32 = 32'($signed(a32) % $signed(b32));
            else                     r32 = 32'($signed(a32) / $signed(b32));
         end
         r = {{32{r32[31]}}, r32};
      end else begin
         if (b == 64'd0) begin
            r = op[1] ? a : '1;
         end else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
            r = op[1] ? 64'd0 : a;
         end else begin
            sp = 1'b0;
            if (op[0] && op[1])      r = a % b;
            else if (op[0])          r = a / b;
            else if (op[1])          r = 64'($signed(a) % $signed(b));
            else                     r = 64'($signed(a) / $signed(b));
         end
      end
      return {sp, r};
   endfunction

   task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input bit sp, input bit push);
      int n;
      n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("issue_wait", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // special cases sit in DONE right after the accept edge; divider ops arrive DIV_LAT edges later
      if (push) sb.push_back('{res: exp, due: cyc + (sp ? 0 : DIV_LAT)});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("reach_idle", 64'(sb.size() == 0 && in_ready), 64'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_res"},   out_res,        64'd0);
      check({tag, "_div_start"}, 64'(div_start), 64'd0);
      check({tag, "_div_x"},     div_x,          64'd0);
      check({tag, "_div_y"},     div_y,          64'd0);
      check({tag, "_div_s"},     64'(div_s),     64'd0);
   endtask

   function automatic logic [63:0] pick_opnd();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'h0000_0000_8000_0000;
         4:       return 64'(unsigned'($urandom_range(0, 40)));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a, b, e;
      bit          sp;
   } vec_t;
   vec_t tv [12];

   initial begin
      int        s0, n;
      bit        seen, bad;
      logic [64:0] rr;
      logic [2:0]  rop;
      logic [63:0] ra, rb;

      // op encoding: {W, REM, UNS}
      tv = '{
         '{3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,               64'hFFFF_FFFF_FFFF_FFFD, 1'b0}, // DIV -7/2
         '{3'b110, 64'h0000_0001_FFFF_FFF9, 64'd2,               64'hFFFF_FFFF_FFFF_FFFF, 1'b0}, // REMW
         '{3'b101, 64'h0000_0000_FFFF_FFFF, 64'd2,               64'h0000_0000_7FFF_FFFF, 1'b0}, // DIVUW
         '{3'b001, 64'd5,                   64'd0,               64'hFFFF_FFFF_FFFF_FFFF, 1'b1}, // DIVU /0
         '{3'b010, 64'hFFFF_FFFF_FFFF_FFF7, 64'd0,               64'hFFFF_FFFF_FFFF_FFF7, 1'b1}, // REM /0
         '{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1}, // DIV ovf
         '{3'b110, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,               1'b1}, // REMW ovf
         '{3'b100, 64'd5,                   64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1}, // DIVW low-word /0
         '{3'b111, 64'hFFFF_FFF0_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1'b1}, // REMUW /0
         '{3'b001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,               1'b0}, // DIVU no ovf
         '{3'b011, 64'd100,                 64'd7,               64'd2,                   1'b0}, // REMU
         '{3'b101, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0,               1'b0}  // DIVUW
      };

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_flush  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // directed vectors, with div_start counted per op
      foreach (tv[i]) begin
         s0 = n_start;
         issue(tv[i].op, tv[i].a, tv[i].b, tv[i].e, tv[i].sp, 1'b1);
         wait_idle();
         check($sformatf("start_count_%0d", i), 64'(n_start - s0), tv[i].sp ? 64'd0 : 64'd1);
      end

      // random ops against the reference model
      for (int i = 0; i < 12; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = pick_opnd();
         rb  = pick_opnd();
         rr  = ref_div(rop, ra, rb);
         issue(rop, ra, rb, rr[63:0], rr[64], 1'b1);
         wait_idle();
      end

      // flush while busy: drain the divider, no out_valid, then a fresh op
      issue(3'b000, 64'hFFFF_FFFF_FFFF_FF9C, 64'd3, 64'd0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      in_flush = 1'b1;
      @(negedge clk);
      in_flush = 1'b0;
      seen = 1'b0;
      bad  = 1'b0;
      n    = 0;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (div_ready) seen = 1'b1;
         else if (in_ready || out_valid) bad = 1'b1;
      end
      check("flush_busy_quiet", 64'(bad), 64'd0);
      check("flush_div_ready_seen", 64'(seen), 64'd1);
      check("drain_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("drain_exit_in_ready", 64'(in_ready), 64'd1);
      check("drain_exit_out_valid", 64'(out_valid), 64'd0);
      issue(3'b001, 64'd100, 64'd7, 64'd14, 1'b0, 1'b1);
      wait_idle();

      // flush on the same cycle as div_ready
      issue(3'b000, 64'd50, 64'd5, 64'd0, 1'b0, 1'b0);
      n = 0;
      while (!div_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("flush_race_ready_seen", 64'(div_ready), 64'd1);
      in_flush = 1'b1;
      @(posedge clk);
      #1;
      in_flush = 1'b0;
      check("flush_race_out_valid", 64'(out_valid), 64'd0);
      check("flush_race_in_ready", 64'(in_ready), 64'd1);

      // flush in IDLE alongside in_valid: not accepted
      @(negedge clk);
      in_valid = 1'b1;
      in_flush = 1'b1;
      in_op    = 3'b001;
      in_a     = 64'd1;
      in_b     = 64'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_flush = 1'b0;
      check("idle_flush_out_valid", 64'(out_valid), 64'd0);
      check("idle_flush_in_ready", 64'(in_ready), 64'd1);

      // flush in DONE drops the result
      out_ready = 1'b0;
      issue(3'b001, 64'd5, 64'd0, 64'd0, 1'b1, 1'b0);
      @(negedge clk);
      check("done_out_valid", 64'(out_valid), 64'd1);
      in_flush = 1'b1;
      @(negedge clk);
      in_flush = 1'b0;
      check("done_flush_out_valid", 64'(out_valid), 64'd0);
      check("done_flush_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;

      // stall in DONE for 5 cycles
      out_ready = 1'b0;
      issue(3'b000, 64'd1000, 64'd10, 64'd100, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      wait_idle();

      // reset mid-BUSY, then a full-latency op
      issue(3'b000, 64'd77, 64'd7, 64'd0, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      issue(3'b000, 64'd77, 64'd7, 64'd11, 1'b0, 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22040127_div_ctrl.md
Name: ysyx_22040127_div_ctrl

Overview:
- Sequencer between the EXU and the 64-bit iterative radix-2 divider (ysyx_22040127_div).
- Decodes the eight RV64M divide ops and prepares the divider operands, including 32-bit W-op extension.
- Resolves divide-by-zero and signed overflow without starting the divider.
- Runs a valid/ready handshake on both sides and absorbs flushes while the divider is in flight, because the divider cannot be aborted.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- DIV_LAT, 68, cycles from the accept edge to out_valid for a divider-path op; used only by the bench for checking.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset. At top level the divider's rst is tied to !rst_n.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_op  in  3  bit0 = unsigned, bit1 = rem (else quotient), bit2 = word op.
- in_a  in  64  dividend.
- in_b  in  64  divisor.
- in_flush  in  1  kill any accepted, not yet delivered op.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- out_res  out  64  final rd value.
- div_x  out  64  divider dividend; held stable until div_ready.
- div_y  out  64  divider divisor; held stable until div_ready.
- div_s  out  1  signed op; held stable until div_ready.
- div_start  out  1  drives the divider's is_div; a one-cycle pulse.
- div_ready  in  1  divider done pulse.
- div_quo  in  64  divider quotient.
- div_rem  in  64  divider remainder.

Behaviour:
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_res = 0, div_start = 0, div_x = 0, div_y = 0, div_s = 0.
- States are IDLE, BUSY, DRAIN and DONE. in_ready = 1 only in IDLE. in_ready is a registered state decode with no combinational path from in_valid.
- Operand preparation on accept (in_valid & in_ready):
  - W signed ops: sext(a[31:0]), sext(b[31:0]).
  - W unsigned ops: zext(a[31:0]), zext(b[31:0]).
  - Non-W ops: operands pass through unchanged.
  - div_s = !in_op[0].
- Special case, divisor == 0 (prepared operands):
  - Quotient = all ones; remainder = prepared dividend.
  - Go to DONE on the accept edge, so out_valid is high 1 cycle after accept. The divider is never started.
- Special case, signed overflow (dividend == 64'h8000_0000_0000_0000 for D ops, or sext(32'h8000_0000) for W ops; divisor == all ones):
  - Quotient = prepared dividend; remainder = 0.
  - Handled like divide-by-zero: direct to DONE, no divider start.
- Divider-path ops:
  - On the accept edge, go to BUSY with div_start = 1. At the next edge div_start returns to 0 and stays 0.
  - div_x, div_y and div_s must not change until div_ready is sampled, because the divider reads x[63] and y[63] during its sign fix-up.
- BUSY exit: when div_ready = 1, capture div_quo or div_rem (selected by op bit1) and go to DONE.
  - Total latency is exactly 68 cycles from the accept edge to out_valid.
- W result rule: out_res = sext(sel[31:0]). This applies to the divider path and the special-case paths alike.
- DONE:
  - out_valid = 1; out_res is stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to IDLE; in_ready is 1 in the next cycle. There is no accept in the same cycle as delivery.
- Flush:
  - in_flush in BUSY: go to DRAIN. In DRAIN, wait for div_ready, discard the result, then go to IDLE. out_valid is never raised.
  - in_flush in DONE: drop the result, go to IDLE.
  - in_flush in IDLE together with in_valid: the request is not accepted.
  - Flush has priority over div_ready in the same cycle: the result is discarded and the next state is IDLE.
- Reset mid-operation: all controller registers return to their reset values asynchronously. The divider resets on the next clk edge. No spurious out_valid after reset deasserts.
- A div_ready pulse in IDLE, DONE or DRAIN-after-completion is ignored.

Decomposition:
- Shared package ysyx_22040127_mdu_pkg holds:
  - op field positions: OP_UNS = 0, OP_REM = 1, OP_W = 2;
  - state localparams for IDLE, BUSY, DRAIN and DONE;
  - the constants INT64_MIN, INT32_MIN_SEXT and DIV_LAT.
- One sub-module: the existing ysyx_22040127_div, instantiated by the EX stage wrapper next to this controller, not inside it.
- Operand preparation and special-case detection are combinational logic within this module.

Test Plan:
- DIV, a = -7, b = 2 -> out_res = -3 (0xFFFF_FFFF_FFFF_FFFD); out_valid exactly 68 cycles after accept; div_start high for exactly 1 cycle.
- REMW, a = 0x0000_0001_FFFF_FFF9, b = 2 -> low word -7 rem 2 = -1 -> out_res = all ones. DIVUW, a = 0xFFFF_FFFF, b = 2 -> out_res = 0x0000_0000_7FFF_FFFF.
- DIVU, b = 0, a = 5 -> out_res = all ones in 1 cycle. REM, b = 0, a = -9 -> out_res = -9. div_start never asserted.
- DIV, a = INT64_MIN, b = -1 -> out_res = INT64_MIN. REMW, a = 0x8000_0000, b = -1 -> out_res = 0. Both complete in 1 cycle.
- DIV issued, in_flush at cycle 10 -> no out_valid; in_ready stays 0 until the divider's ready pulse, then returns to 1. A new DIVU 100 / 7 afterwards returns 14.
- out_ready held low 5 cycles in DONE -> out_res stable and in_ready = 0 throughout. rst_n pulsed low mid-BUSY -> all outputs return to reset values immediately, and a subsequent op completes in 68 cycles.
